// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done
// handshake, results registered and held until the next accepted operation.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [CW-1:0]    cnt;
    logic             zero_div;

    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Stored partial remainder is always below the divisor, so WIDTH bits hold
    // it; only the shifted trial value needs the extra bit.
    always_comb begin
        rem_shift = {rem_r, quo_r[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, div_r});
        rem_next  = rem_shift[WIDTH-1:0];
        quo_next  = {quo_r[WIDTH-2:0], 1'b0};
        if (rem_ge) begin
            rem_next    = WIDTH'(rem_shift - {1'b0, div_r});
            quo_next[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem_r       <= '0;
            quo_r       <= '0;
            div_r       <= '0;
            cnt         <= '0;
            zero_div    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        div_r    <= divisor;
                        quo_r    <= dividend;
                        rem_r    <= '0;
                        cnt      <= '0;
                        zero_div <= (divisor == '0);
                        busy     <= (divisor != '0);
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // A zero divisor spends its one RUN cycle with busy low.
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= quo_r;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        zero_div    <= 1'b0;
                        state       <= DONE;
                    end else begin
                        rem_r <= rem_next;
                        quo_r <= quo_next;
                        if (cnt == CW'(WIDTH - 1)) begin
                            quotient    <= quo_next;
                            remainder   <= rem_next;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at issue time,
// compared when done pulses; latency, busy and hold behaviour checked inline.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_done = 1'b0;

    seq_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            check_eq("done_not_busy", busy, 0);
            check_eq("done_one_cycle", prev_done, 0);
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("quotient", quotient, e.q);
                check_eq("remainder", remainder, e.r);
                check_eq("div_by_zero", div_by_zero, e.dz);
            end
        end
        prev_done = rst_n && done;
    end

    // Issues one operation (assumes the DUT is ready) and waits for its done.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n;
        logic saw_busy;
        if (b == 0) begin
            e.q = 8'hFF; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        saw_busy = busy;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) saw_busy = 1'b1;
        end
        check_eq("latency", n, (b == 0) ? 2 : 9);
        check_eq("busy_seen", saw_busy, (b != 0));
    endtask

    initial begin
        logic [7:0] ra, rb;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_quotient", quotient, 0);
        check_eq("rst_remainder", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        @(posedge clk);
        #1;

        do_op(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_quotient", quotient, 28);
        check_eq("hold_remainder", remainder, 4);

        do_op(8'd255, 8'd1);
        do_op(8'd5, 8'd9);
        do_op(8'd255, 8'd255);
        do_op(8'd0, 8'd3);

        do_op(8'd100, 8'd0);
        do_op(8'd10, 8'd3);

        // Start pulsed mid-RUN must be ignored; results held while running.
        @(posedge clk);
        #1;
        sb.push_back('{q: 8'd28, r: 8'd4, dz: 1'b0});
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("run_busy", busy, 1);
        check_eq("run_hold_quotient", quotient, 3);
        dividend = 8'd9; divisor = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        begin
            int n = 0;
            while (!done && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check_eq("ignored_start_latency", n, 4);
        end
        do_op(8'd9, 8'd3);

        // Asynchronous reset at step 4 of a running operation.
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_quotient", quotient, 0);
        check_eq("arst_remainder", remainder, 0);
        check_eq("arst_dbz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("arst_no_done", done, 0);
        do_op(8'd50, 8'd6);

        for (int a = 0; a < 256; a++) do_op(8'(a), 8'd0);
        for (int i = 0; i < 3000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb);
        end

        repeat (3) @(posedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
